// File: rtl/rle_enc_axis.sv
// Streaming run-length encoder with AXI-style valid/ready on both sides.
// Value words carry flag bit W-1 = 0, count words set it; disabled -> registered pass-through.
module rle_enc_axis #(
  parameter int DW = 32,
  parameter int KW = DW / 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          enable_i,
  input  logic [1:0]    rle_mode_i,
  input  logic [KW-1:0] disabledGroups_i,
  input  logic          flush_i,
  input  logic [DW-1:0] sti_data_i,
  input  logic [KW-1:0] sti_keep_i,
  input  logic          sti_valid_i,
  output logic          sti_ready_o,
  output logic [DW-1:0] sto_data_o,
  output logic [KW-1:0] sto_keep_o,
  output logic          sto_valid_o,
  input  logic          sto_ready_i
);

  typedef enum logic [1:0] {IDLE, RUN, EMIT_VAL, REFRESH} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] count_q, count_d;
  logic [DW-1:0] last_q, last_d;
  logic          pend_q, pend_d;
  logic [1:0]    mode_q;
  logic [KW-1:0] dg_q;
  logic          rdy_q;
  logic [DW-1:0] stoData_q;
  logic          stoValid_q;
  logic [KW-1:0] stoKeep_q;

  logic [KW-1:0] dgEff;
  logic [DW-1:0] wMask, lowMask, flagBit, sampleVal, countInc, word;
  logic          slotFree, accept, isSample, load;

  // Configuration follows the live inputs only while IDLE; a run keeps what it started with.
  assign dgEff = (state_q == IDLE) ? disabledGroups_i : dg_q;

  always_comb begin
    wMask = '0;
    for (int k = 0; k < KW; k++) begin
      wMask[8*k +: 8] = {8{~dgEff[k]}};
    end
  end

  assign lowMask     = wMask >> 1;
  assign flagBit     = wMask & ~lowMask;
  assign slotFree    = !stoValid_q || sto_ready_i;
  assign sti_ready_o = rdy_q && slotFree && (state_q != EMIT_VAL) && !pend_q;
  assign accept      = sti_valid_i && sti_ready_o;
  assign isSample    = accept && (|(sti_keep_i & ~dgEff));
  assign sampleVal   = sti_data_i & lowMask;
  assign countInc    = count_q + DW'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    load    = 1'b0;
    word    = '0;
    unique case (state_q)
      IDLE: begin
        if (isSample) begin
          load = 1'b1;
          if (!enable_i) begin
            word = sti_data_i;
          end else begin
            word    = sampleVal;
            last_d  = sampleVal;
            count_d = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (pend_q) begin
          if (count_q == '0) begin
            state_d = IDLE;
          end else if (slotFree) begin
            load    = 1'b1;
            word    = flagBit | count_q;
            count_d = '0;
            state_d = IDLE;
          end
        end else if (isSample) begin
          if (sampleVal == last_q) begin
            // Saturated runs are split into an all-ones count word.
            if (countInc == lowMask) begin
              load    = 1'b1;
              word    = flagBit | lowMask;
              count_d = '0;
              state_d = (mode_q == 2'd1) ? REFRESH : RUN;
            end else begin
              count_d = countInc;
            end
          end else if (count_q == '0) begin
            load   = 1'b1;
            word   = sampleVal;
            last_d = sampleVal;
          end else begin
            load    = 1'b1;
            word    = flagBit | count_q;
            last_d  = sampleVal;
            count_d = '0;
            state_d = EMIT_VAL;
          end
        end
      end
      EMIT_VAL: begin
        if (slotFree) begin
          load    = 1'b1;
          word    = last_q;
          count_d = '0;
          state_d = RUN;
        end
      end
      REFRESH: begin
        if (pend_q) begin
          count_d = '0;
          state_d = IDLE;
        end else if (isSample) begin
          load    = 1'b1;
          word    = sampleVal;
          last_d  = sampleVal;
          count_d = '0;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    // A flush or disable seen alongside a sample is serviced on a later cycle.
    pend_d = (state_d != IDLE) && (pend_q || flush_i || !enable_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      count_q    <= '0;
      last_q     <= '0;
      pend_q     <= 1'b0;
      mode_q     <= 2'd0;
      dg_q       <= '0;
      rdy_q      <= 1'b0;
      stoData_q  <= '0;
      stoValid_q <= 1'b0;
      stoKeep_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      last_q    <= last_d;
      pend_q    <= pend_d;
      rdy_q     <= 1'b1;
      stoKeep_q <= ~disabledGroups_i;
      if (state_q == IDLE) begin
        mode_q <= rle_mode_i;
        dg_q   <= disabledGroups_i;
      end
      if (load) begin
        stoData_q  <= word;
        stoValid_q <= 1'b1;
      end else if (sto_ready_i) begin
        stoValid_q <= 1'b0;
      end
    end
  end

  assign sto_data_o  = stoData_q;
  assign sto_valid_o = stoValid_q;
  assign sto_keep_o  = stoKeep_q;

endmodule

// File: tb/tb_rle_enc_axis.sv
// Directed bench for rle_enc_axis (DW=32): run/count words, saturation, masks,
// backpressure, flush, disable and asynchronous reset.
module tb_rle_enc_axis;

  logic        clk, rst_n, enable, flush, sti_valid, sti_ready, sto_valid, sto_ready;
  logic [1:0]  rle_mode;
  logic [3:0]  dg, sti_keep, sto_keep;
  logic [31:0] sti_data, sto_data;

  int total = 0;
  int bad = 0;
  logic [31:0] obsQ[$];
  logic [31:0] expQ[$];

  rle_enc_axis #(.DW(32), .KW(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .rle_mode_i(rle_mode),
    .disabledGroups_i(dg), .flush_i(flush), .sti_data_i(sti_data),
    .sti_keep_i(sti_keep), .sti_valid_i(sti_valid), .sti_ready_o(sti_ready),
    .sto_data_o(sto_data), .sto_keep_o(sto_keep), .sto_valid_o(sto_valid),
    .sto_ready_i(sto_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every word handed downstream.
  always @(negedge clk) begin
    if (rst_n && sto_valid && sto_ready) obsQ.push_back(sto_data);
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic [3:0] keep);
    logic got;
    got = 1'b0;
    sti_data  = data;
    sti_keep  = keep;
    sti_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = sti_ready;
      @(posedge clk);
      #1;
    end
    sti_valid = 1'b0;
    if (!got) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flushPulse();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic checkWords(input string tag);
    logic [63:0] obs;
    checkOutput({tag, "_count"}, 64'(obsQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      obs = (i < obsQ.size()) ? {32'd0, obsQ[i]} : 64'hx;
      checkOutput($sformatf("%s_w%0d", tag, i), obs, {32'd0, expQ[i]});
    end
    obsQ.delete();
    expQ.delete();
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b1; flush = 1'b0; rle_mode = 2'd0; dg = 4'b1110;
    sti_valid = 1'b0; sti_data = '0; sti_keep = '0; sto_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_sto_valid", 64'(sto_valid), 64'd0);
    checkOutput("rst_sti_ready", 64'(sti_ready), 64'd0);
    checkOutput("rst_sto_keep", 64'(sto_keep), 64'd0);
    checkOutput("rst_sto_data", 64'(sto_data), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_sti_ready", 64'(sti_ready), 64'd1);
    checkOutput("post_rst_sto_keep", 64'(sto_keep), 64'h1);
    obsQ.delete();

    // Basic run, 8-bit width
    applyStimulus(32'h41414141, 4'hF);
    for (int i = 0; i < 3; i++) applyStimulus(32'h43434343, 4'hF);
    applyStimulus(32'h44444444, 4'hF);
    flushPulse();
    idleCycles(4);
    expQ = '{32'h41, 32'h43, 32'h82, 32'h44};
    checkWords("basic");
    checkOutput("basic_keep", 64'(sto_keep), 64'h1);

    // Saturation, continuous count
    for (int i = 0; i < 130; i++) applyStimulus(32'h4C4C4C4C, 4'hF);
    applyStimulus(32'h4D4D4D4D, 4'hF);
    flushPulse();
    idleCycles(4);
    expQ = '{32'h4C, 32'hFF, 32'h82, 32'h4D};
    checkWords("sat_m0");

    // Saturation, value refresh
    rle_mode = 2'd1;
    idleCycles(1);
    for (int i = 0; i < 130; i++) applyStimulus(32'h4C4C4C4C, 4'hF);
    applyStimulus(32'h4D4D4D4D, 4'hF);
    flushPulse();
    idleCycles(4);
    expQ = '{32'h4C, 32'hFF, 32'h4C, 32'h81, 32'h4D};
    checkWords("sat_m1");

    // 16-bit width, keep qualification, dropped top bit
    rle_mode = 2'd0;
    dg = 4'b1100;
    idleCycles(1);
    for (int i = 0; i < 3; i++) applyStimulus(32'h00001234, 4'hF);
    applyStimulus(32'hAAAAAAAA, 4'b1100);
    applyStimulus(32'h00005678, 4'hF);
    applyStimulus(32'h00009234, 4'hF);
    flushPulse();
    idleCycles(4);
    expQ = '{32'h1234, 32'h8002, 32'h5678, 32'h1234};
    checkWords("width16");
    checkOutput("width16_keep", 64'(sto_keep), 64'h3);

    // Backpressure at the end of a run
    dg = 4'b1110;
    idleCycles(1);
    applyStimulus(32'h41414141, 4'hF);
    for (int i = 0; i < 3; i++) applyStimulus(32'h43434343, 4'hF);
    sto_ready = 1'b0;
    applyStimulus(32'h44444444, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_data_c%0d", i), 64'(sto_data), 64'h82);
      checkOutput($sformatf("bp_valid_c%0d", i), 64'(sto_valid), 64'd1);
      checkOutput($sformatf("bp_ready_c%0d", i), 64'(sti_ready), 64'd0);
    end
    @(posedge clk);
    #1 sto_ready = 1'b1;
    idleCycles(4);
    flushPulse();
    idleCycles(4);
    expQ = '{32'h41, 32'h43, 32'h82, 32'h44};
    checkWords("backpressure");

    // Explicit flush ends the run and returns to IDLE
    for (int i = 0; i < 5; i++) applyStimulus(32'h47474747, 4'hF);
    flushPulse();
    idleCycles(4);
    applyStimulus(32'h47474747, 4'hF);
    flushPulse();
    idleCycles(4);
    expQ = '{32'h47, 32'h84, 32'h47};
    checkWords("flush");

    // Disable ends the run, then pass-through with latency 1
    for (int i = 0; i < 5; i++) applyStimulus(32'h47474747, 4'hF);
    enable = 1'b0;
    idleCycles(5);
    applyStimulus(32'h12345678, 4'hF);
    checkOutput("pass_lat_valid", 64'(sto_valid), 64'd1);
    checkOutput("pass_lat_data", 64'(sto_data), 64'h12345678);
    applyStimulus(32'hDEADBEEF, 4'hF);
    idleCycles(4);
    expQ = '{32'h47, 32'h84, 32'h12345678, 32'hDEADBEEF};
    checkWords("disable");

    // Asynchronous reset mid-run
    enable = 1'b1;
    idleCycles(1);
    applyStimulus(32'h41414141, 4'hF);
    applyStimulus(32'h43434343, 4'hF);
    applyStimulus(32'h43434343, 4'hF);
    sto_ready = 1'b0;
    applyStimulus(32'h44444444, 4'hF);
    checkOutput("pre_rst_valid", 64'(sto_valid), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 64'(sto_valid), 64'd0);
    checkOutput("async_rst_ready", 64'(sti_ready), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    sto_ready = 1'b1;
    @(posedge clk);
    #1;
    obsQ.delete();
    applyStimulus(32'h41414141, 4'hF);
    idleCycles(3);
    flushPulse();
    idleCycles(4);
    expQ = '{32'h41};
    checkWords("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
